temp_sampler: RTL
=================

TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 50000: clock cycles from one conversion request to the next (min 16).
REQ-002 Parameter AVG_LOG2, default 3: log2 of samples averaged per output word (range 0..4).
REQ-003 Parameter CHANNEL, default 5'd17: ADC channel of the on-die temperature diode.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  1 = periodic sampling runs; 0 = finish current conversion, then idle.
REQ-007 cmd_valid  output  1  conversion request to ADC.
REQ-008 cmd_channel  output  5  channel for the request; constant CHANNEL.
REQ-009 cmd_ready  input  1  ADC accepts the request when cmd_valid and cmd_ready are both 1.
REQ-010 rsp_valid  input  1  one-cycle strobe: ADC result present.
REQ-011 rsp_data  input  12  raw ADC code; lower code = hotter.
REQ-012 temp  output  12  averaged raw code, held between updates.
REQ-013 temp_valid  output  1  one-cycle pulse when temp updates.
REQ-014 err  output  1  sticky timeout flag (only with macro, see Configuration).

Function
REQ-015 FSM states: IDLE, REQ, WAIT, WAIT_PERIOD.
REQ-016 IDLE -> REQ when enable=1; period counter loads SAMPLE_PERIOD-1 on that transition.
REQ-017 REQ: cmd_valid=1; cmd_valid stays high and cmd_channel stable until cmd_ready=1; then -> WAIT.
REQ-018 WAIT: on rsp_valid, add rsp_data to 16-bit accumulator and increment sample count; -> WAIT_PERIOD.
REQ-019 rsp_valid in any state other than WAIT is ignored.
REQ-020 Period counter decrements every cycle outside IDLE; when it reaches 0 in WAIT_PERIOD -> REQ (enable=1) or IDLE (enable=0), reloading SAMPLE_PERIOD-1.
REQ-021 If the period expires while still in REQ/WAIT, the next request issues immediately after the response; no request is dropped or duplicated.
REQ-022 When count reaches 2^AVG_LOG2: temp <= accumulator[AVG_LOG2+11:AVG_LOG2] (truncating divide), including the sample arriving that cycle; temp_valid=1 the following cycle; accumulator and count clear the same cycle.
REQ-023 AVG_LOG2=0: temp = rsp_data, one-cycle latency from rsp_valid to temp_valid.
REQ-024 enable falling mid-average: partial accumulator is kept; averaging resumes on re-enable.
REQ-025 enable falling in REQ: request stays asserted until accepted (no handshake abort).

Reset
REQ-026 On rst_n=0 (asynchronous): state=IDLE, cmd_valid=0, temp=12'hFFF (coldest code, so hot-threshold consumers do not fire), temp_valid=0, err=0, accumulator=0, count=0, period counter=SAMPLE_PERIOD-1.
REQ-027 Reset deassertion takes effect on the next rising clk edge; first request occurs no earlier than one cycle after rst_n rises with enable=1.

Configuration
REQ-028 Macro TEMP_SAMPLER_TIMEOUT_EN defined: WAIT longer than 1024 cycles sets err=1 (sticky until reset), discards the pending sample, and transitions to WAIT_PERIOD.
REQ-029 Macro undefined: no timeout; WAIT waits indefinitely; err tied to 0.

Structure
REQ-030 Shared package temp_pkg holds the FSM state enum, TEMP_W=12, TEMP_RESET_CODE=12'hFFF, and the timeout limit.
REQ-031 One sub-module, temp_avg (accumulator, counter, shift-divide), instantiated once; FSM and handshake stay in temp_sampler.

Verification
REQ-032 AVG_LOG2=2, enable=1, cmd_ready=1, responses 1000,1001,1002,1003 -> one temp_valid pulse, temp=1001.
REQ-033 cmd_ready held 0 for 20 cycles -> cmd_valid held high with channel 17 throughout, exactly one acceptance.
REQ-034 AVG_LOG2=0, rsp_data=3600 -> temp=3600 and temp_valid exactly one cycle after rsp_valid.
REQ-035 rst_n low mid-WAIT with 3 of 8 samples accumulated -> temp=12'hFFF immediately, accumulator cleared, next output averages 8 fresh samples.
REQ-036 With TEMP_SAMPLER_TIMEOUT_EN, no rsp_valid for 1100 cycles -> err=1 at cycle 1025 of WAIT, next request issues after the period; without the macro, err stays 0 and FSM stays in WAIT.
REQ-037 Stray rsp_valid in WAIT_PERIOD -> no change to accumulator, count, or temp.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared types and constants for the on-die temperature sampler.
package temp_pkg;

  localparam int unsigned TEMP_W          = 12;
  localparam int unsigned ACC_W           = 16;
  localparam logic [11:0] TEMP_RESET_CODE = 12'hFFF;
  localparam int unsigned TIMEOUT_LIMIT   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WAIT_PERIOD
  } state_e;

endpackage

// File: rtl/temp_avg.sv
// Block averager: accumulates 2^AVG_LOG2 raw ADC codes and emits their truncated mean.
module temp_avg
  import temp_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid_i,
  input  logic [TEMP_W-1:0] sample_data_i,
  output logic [TEMP_W-1:0] temp_o,
  output logic              temp_valid_o
);

  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_FULL = NSAMP[CNT_W-1:0];

  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              temp_valid_q, temp_valid_d;

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    temp_d       = temp_q;
    temp_valid_d = 1'b0;
    sum          = acc_q + {{(ACC_W-TEMP_W){1'b0}}, sample_data_i};
    cnt_inc      = cnt_q + CNT_W'(1);
    if (sample_valid_i) begin
      // The sample arriving this cycle completes the block: divide the sum including it.
      if (cnt_inc == CNT_FULL) begin
        temp_d       = sum[AVG_LOG2 +: TEMP_W];
        temp_valid_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      temp_q       <= TEMP_RESET_CODE;
      temp_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
    end
  end

  assign temp_o       = temp_q;
  assign temp_valid_o = temp_valid_q;

endmodule

// File: rtl/temp_sampler.sv
// Periodic temperature-diode sampler: issues ADC requests every SAMPLE_PERIOD cycles and averages results.
// Optional WAIT timeout with sticky err is enabled by defining TEMP_SAMPLER_TIMEOUT_EN.
module temp_sampler
  import temp_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter int unsigned AVG_LOG2      = 3,
  parameter logic [4:0]  CHANNEL       = 5'd17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              cmd_valid,
  output logic [4:0]        cmd_channel,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [TEMP_W-1:0] rsp_data,
  output logic [TEMP_W-1:0] temp,
  output logic              temp_valid,
  output logic              err
);

  localparam int unsigned PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(SAMPLE_PERIOD - 1);

  state_e           state_q;
  logic [PER_W-1:0] per_q;
  logic             pend_q;
  logic             cmd_valid_q;
  logic             per_zero;
  logic             sample_take;
  logic             restart;
  logic             timeout;

  assign per_zero    = (per_q == '0);
  assign sample_take = (state_q == ST_WAIT) && rsp_valid;
  // A period that expired during REQ/WAIT is owed immediately after the response.
  assign restart     = pend_q || per_zero;

`ifdef TEMP_SAMPLER_TIMEOUT_EN
  logic [10:0] wait_cnt_q;
  logic        err_q;

  assign timeout = (state_q == ST_WAIT) && !rsp_valid && (wait_cnt_q == 11'(TIMEOUT_LIMIT));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q != ST_WAIT) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != '1) begin
        wait_cnt_q <= wait_cnt_q + 11'(1);
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      per_q       <= PER_RELOAD;
      pend_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      if (state_q != ST_IDLE) begin
        per_q <= per_zero ? PER_RELOAD : per_q - PER_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q     <= ST_REQ;
            cmd_valid_q <= 1'b1;
            per_q       <= PER_RELOAD;
          end
        end
        ST_REQ: begin
          if (per_zero) begin
            pend_q <= 1'b1;
          end
          if (cmd_ready) begin
            state_q     <= ST_WAIT;
            cmd_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (per_zero) begin
            pend_q <= 1'b1;
          end
          if (timeout) begin
            state_q <= ST_WAIT_PERIOD;
            pend_q  <= 1'b0;
          end else if (rsp_valid) begin
            pend_q <= 1'b0;
            if (!restart) begin
              state_q <= ST_WAIT_PERIOD;
            end else if (enable) begin
              state_q     <= ST_REQ;
              cmd_valid_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_WAIT_PERIOD: begin
          if (per_zero) begin
            if (enable) begin
              state_q     <= ST_REQ;
              cmd_valid_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  temp_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid_i(sample_take),
    .sample_data_i (rsp_data),
    .temp_o        (temp),
    .temp_valid_o  (temp_valid)
  );

  assign cmd_valid   = cmd_valid_q;
  assign cmd_channel = CHANNEL;

endmodule
